sync_fifo_ctrl: RTL

- Single-clock FIFO controller that sits directly upstream of the team's 1024x32 one-clock dual-port RAM and drives all of its ports: wen, ren, waddr, raddr, d_in. It consumes the RAM's registered d_out.
- Exposes a push/pop interface with full/empty, almost-full/almost-empty, occupancy count and sticky error flags.
- Together with the RAM it forms the design's synchronous FIFO. The RAM stays external to this block.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_ptr.sv | 32 +++
 rtl/sync_fifo_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO controller and its pointer sub-module.
package fifo_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 32;
    localparam int DEPTH_DEF    = 1 << ADDR_W_DEF;
    localparam int AF_LEVEL_DEF = 1020;
    localparam int AE_LEVEL_DEF = 4;

    // Pointer carries one extra wrap bit above the RAM address.
    typedef logic [ADDR_W_DEF:0] ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: address bits plus a wrap MSB, advanced by one per accepted operation.
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int W = ADDR_W_DEF + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] ptr,
    output logic [W-1:0] ptr_nxt
);

    // Next pointer value; natural binary overflow provides the wrap.
    always_comb begin
        if (inc) begin
            ptr_nxt = ptr + W'(1);
        end else begin
            ptr_nxt = ptr;
        end
    end

    // Pointer register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule : fifo_ptr

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller driving an external 1-cycle-read dual-port RAM.
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int AF_LEVEL = AF_LEVEL_DEF,
    parameter int AE_LEVEL = AE_LEVEL_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr,
    output logic              ram_wen,
    output logic              ram_ren,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int PW = ADDR_W + 1;

    logic [PW-1:0] wr_ptr_s;
    logic [PW-1:0] rd_ptr_s;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [PW-1:0] count_nxt_s;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic          ovf_evt_s;
    logic          udf_evt_s;

    logic [PW-1:0] count_r;
    logic          full_r;
    logic          empty_r;
    logic          af_r;
    logic          ae_r;
    logic          overflow_r;
    logic          underflow_r;
    logic          pop_valid_r;

    // Acceptance; rst_n gating keeps RAM strobes low for the whole reset window.
    always_comb begin
        pop_ok_s  = rst_n & pop & ~empty_r;
        push_ok_s = rst_n & push & (~full_r | pop_ok_s);
        ovf_evt_s = push & full_r & ~pop_ok_s;
        udf_evt_s = pop & empty_r;
    end

    fifo_ptr #(.W(PW)) u_wr_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (push_ok_s),
        .ptr     (wr_ptr_s),
        .ptr_nxt (wr_ptr_nxt_s)
    );

    fifo_ptr #(.W(PW)) u_rd_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (pop_ok_s),
        .ptr     (rd_ptr_s),
        .ptr_nxt (rd_ptr_nxt_s)
    );

    // Occupancy next state.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + PW'(1);
            2'b01:   count_nxt_s = count_r - PW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Registered count, status flags, sticky errors and pop strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= '0;
            full_r      <= 1'b0;
            empty_r     <= 1'b1;
            af_r        <= 1'b0;
            ae_r        <= 1'b1;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            pop_valid_r <= 1'b0;
        end else begin
            count_r     <= count_nxt_s;
            full_r      <= (wr_ptr_nxt_s[ADDR_W] != rd_ptr_nxt_s[ADDR_W]) &&
                           (wr_ptr_nxt_s[ADDR_W-1:0] == rd_ptr_nxt_s[ADDR_W-1:0]);
            empty_r     <= (wr_ptr_nxt_s == rd_ptr_nxt_s);
            af_r        <= (count_nxt_s >= PW'(AF_LEVEL));
            ae_r        <= (count_nxt_s <= PW'(AE_LEVEL));
            // A new error wins over a coincident clear.
            overflow_r  <= ovf_evt_s | (overflow_r & ~err_clr);
            underflow_r <= udf_evt_s | (underflow_r & ~err_clr);
            pop_valid_r <= pop_ok_s;
        end
    end

    // Output mapping; RAM side is combinational so the RAM captures on the same edge.
    always_comb begin
        ram_wen      = push_ok_s;
        ram_waddr    = wr_ptr_s[ADDR_W-1:0];
        ram_wdata    = push_data;
        ram_ren      = pop_ok_s;
        ram_raddr    = rd_ptr_s[ADDR_W-1:0];
        pop_data     = ram_rdata;
        pop_valid    = pop_valid_r;
        count        = count_r;
        full         = full_r;
        empty        = empty_r;
        almost_full  = af_r;
        almost_empty = ae_r;
        overflow     = overflow_r;
        underflow    = underflow_r;
    end

endmodule : sync_fifo_ctrl
